// File: rtl/sensor_stream_tx.sv
// rtl/sensor_stream_tx.sv - FIFO-buffered sensor bus transmitter with programmable gaps and bursts
module sensor_stream_tx #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 2,
    parameter int BURST_MAX  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             enable,
    input  logic             burst_en,
    output logic [WIDTH-1:0] sensor_data,
    output logic             data_valid,
    output logic             busy,
    output logic [15:0]      tx_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    // Gap counter keeps at least one bit so GAP_CYCLES = 0 still elaborates.
    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam int BW = $clog2(BURST_MAX + 1);

    localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
    localparam logic [GW-1:0] GAP_LOAD    = GW'(GAP_CYCLES);
    localparam logic [BW-1:0] BURST_LIMIT = BW'(BURST_MAX);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    logic [GW-1:0]    gap_cnt;
    logic [GW-1:0]    gap_next;
    logic [BW-1:0]    burst_cnt;
    logic [BW-1:0]    burst_next;
    logic             valid_next;

    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);
    // No bypass: a pop in the same cycle does not open the FIFO while it is full.
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;
    assign busy       = (state != IDLE) || !fifo_empty;

    // Sample storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Next-state decisions: start from IDLE, extend a burst in SEND, count down the gap.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        valid_next = 1'b0;
        gap_next   = gap_cnt;
        burst_next = burst_cnt;
        case (state)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    pop        = 1'b1;
                    valid_next = 1'b1;
                    burst_next = BW'(1);
                    state_next = SEND;
                end
            end
            SEND: begin
                if (burst_en && enable && (burst_cnt < BURST_LIMIT) && !fifo_empty) begin
                    pop        = 1'b1;
                    valid_next = 1'b1;
                    burst_next = burst_cnt + BW'(1);
                end else begin
                    burst_next = '0;
                    if (GAP_CYCLES == 0) begin
                        state_next = IDLE;
                    end else begin
                        gap_next   = GAP_LOAD;
                        state_next = GAP;
                    end
                end
            end
            GAP: begin
                gap_next = gap_cnt - GW'(1);
                if (gap_cnt == GW'(1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and counter registers; reset clears the bus asynchronously, even mid-burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            burst_cnt   <= '0;
            data_valid  <= 1'b0;
            sensor_data <= '0;
            tx_count    <= '0;
        end else begin
            state      <= state_next;
            gap_cnt    <= gap_next;
            burst_cnt  <= burst_next;
            data_valid <= valid_next;
            if (pop) begin
                sensor_data <= mem[rd_ptr];
                tx_count    <= tx_count + 16'd1;
            end
        end
    end

    // Occupancy must stay within 0..DEPTH; push and pop qualifications guarantee it.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && fifo_full));
    assert property (@(posedge clk) disable iff (!rst_n) !(pop && fifo_empty));

endmodule

// File: doc/sensor_stream_tx.md
Name: sensor_stream_tx

Overview:
Sensor-side transmitter that drives the `sensor_data`/`data_valid` pulse interface consumed by the SensorInterface block. It accepts samples from an upstream producer through a valid/ready port and buffers them in a small FIFO. It replays them onto the sensor bus with programmable inter-sample gaps, either as single pulses or as back-to-back bursts. It replaces hand-written bench stimulus and serves as the synthesizable sensor front-end model.

Parameters:
- WIDTH, 16, sample width; matches `sensor_data`.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- GAP_CYCLES, 2, idle cycles (`data_valid` = 0) after each single pulse or burst; 0 is legal.
- BURST_MAX, 3, maximum consecutive `data_valid` cycles in burst mode; must be at least 1.

Ports:
- clk, input, 1, single system clock; all state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_data, input, WIDTH, sample from the producer.
- in_valid, input, 1, producer has a sample on `in_data`.
- in_ready, output, 1, FIFO can accept; combinational, equal to !full.
- enable, input, 1, permits starting new transmissions.
- burst_en, input, 1, allows back-to-back samples up to BURST_MAX.
- sensor_data, output, WIDTH, registered sample on the sensor bus.
- data_valid, output, 1, registered; high for exactly the cycles a sample is presented.
- busy, output, 1, FSM is not in IDLE, or the FIFO is non-empty.
- tx_count, output, 16, number of samples transmitted; wraps from 0xFFFF to 0.

Behaviour:
- Reset (async assert, sync release):
  - FIFO flushed; `sensor_data` = 0, `data_valid` = 0, `tx_count` = 0, `busy` = 0.
  - `in_ready` = 1; FSM goes to IDLE; gap and burst counters cleared.
  - Reset asserted mid-burst drops `data_valid` immediately, without waiting for a clock edge.
- FIFO:
  - A push happens on any edge where `in_valid` && `in_ready`.
  - A pop happens only on a SEND-load edge (see FSM).
  - Push and pop on the same edge are allowed when not full; occupancy is then unchanged.
  - At full, `in_ready` = 0 even if a pop happens that cycle; no bypass.
  - Pointers wrap modulo DEPTH.
  - Occupancy counter runs 0..DEPTH. No overflow or underflow is possible by construction; an assertion fires if either occurs.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - `data_valid` = 0.
  - If `enable` && FIFO non-empty at an edge: pop the head into `sensor_data`, set `data_valid` = 1, set burst_cnt = 1, go to SEND.
- SEND: one sample is visible per cycle. At each edge:
  - Continue bursting if `burst_en` && `enable` && burst_cnt < BURST_MAX && FIFO non-empty. Pop the next sample into `sensor_data`, keep `data_valid` = 1, increment burst_cnt, stay in SEND.
  - Otherwise set `data_valid` = 0. If GAP_CYCLES = 0, go to IDLE; else load gap_cnt = GAP_CYCLES and go to GAP.
  - With `burst_en` = 0, every sample is a single 1-cycle pulse.
- GAP:
  - `data_valid` = 0; gap_cnt decrements each edge.
  - When gap_cnt = 1, go to IDLE.
  - Samples arriving during GAP are buffered, not sent.
- Pulse spacing: consecutive separated transmissions are at least GAP_CYCLES+1 idle cycles apart. That is GAP_CYCLES in GAP plus 1 in IDLE.
- Latency: a sample pushed at edge t into an empty FIFO with the FSM in IDLE and `enable` = 1 appears with `data_valid` = 1 from edge t+1 to edge t+2.
- `sensor_data` holds its last value while `data_valid` = 0; it never changes except on a pop edge or reset.
- `tx_count` increments on every pop edge.
- Dropping `enable`:
  - In IDLE it blocks starts.
  - In SEND it ends the burst after the current sample, with the normal GAP following.
  - It never truncates a visible pulse.
- Changes to `burst_en` take effect at the next SEND decision edge.

Test Plan:
- Reset mid-burst:
  - Stimulus: push 0x40, 0x50, 0x60 with `burst_en` = 1, then assert `rst_n` = 0 during the second pulse.
  - Required: `data_valid` and `sensor_data` go to 0 immediately; after release, `in_ready` = 1, `busy` = 0, and `tx_count` = 0.
- Single pulses:
  - Stimulus: `enable` = 1, `burst_en` = 0; push 0x20, 0x80, 0x00, 0xFF back-to-back.
  - Required: four 1-cycle pulses carrying 0x20, 0x80, 0x00, 0xFF in order, each separated by exactly 3 low cycles (GAP_CYCLES = 2); `tx_count` = 4.
- Burst limit:
  - Stimulus: `burst_en` = 1; push 0x40, 0x50, 0x60, 0x70.
  - Required: `data_valid` high for 3 consecutive cycles (0x40, 0x50, 0x60), then 3 low cycles, then a 1-cycle pulse of 0x70.
- FIFO full and simultaneous push/pop:
  - Stimulus: `enable` = 0; push 5 samples 0x1..0x5.
  - Required: `in_ready` falls after 4 accepts and 0x5 is held by the producer. Raising `enable` pops 0x1, `in_ready` rises, and 0x5 is accepted; the output order is 0x1..0x5.
- Enable drop and hold:
  - Stimulus: drop `enable` during the first cycle of a 3-sample burst.
  - Required: only that sample is sent; `sensor_data` holds its value while `data_valid` = 0; the remaining samples resume when `enable` is high again.
- Counter wrap:
  - Stimulus: preload the state so `tx_count` = 0xFFFF via 65535 pushes, or force it in the bench, then send one more sample.
  - Required: `tx_count` = 0x0000.
